// File: rtl/sccb_cam_responder_pkg.sv
// sccb_pkg: shared types and constants for the SCCB camera-port responder.
//   sccb_resp_state_t : responder FSM state encoding
//   SCCB_CAM_ADDR     : default 7-bit target address
//   SCCB_BITS         : bits per SCCB byte (excluding the ninth ACK bit)
package sccb_pkg;
    typedef enum logic [3:0] {
        IDLE, DEVADR, DEV_ACK, REGADR, REG_ACK, WRDATA, WR_ACK, RDDATA, RD_ACK, IGNORE
    } sccb_resp_state_t;

    localparam logic [6:0] SCCB_CAM_ADDR = 7'h21;
    localparam logic [3:0] SCCB_BITS     = 4'd8;
endpackage

// File: rtl/sccb_cam_responder_if.sv
// sccb_cam_responder_if: SCCB/I2C bus seen by the responder.
//   iScl   : bus SCL (raw)
//   iSda   : bus SDA (raw, wired-AND value)
//   oSdaOe : 1 = responder pulls SDA low
// Modports: master (bus controller / bench side), slave (responder side).
interface sccb_cam_responder_if;
    logic iScl;
    logic iSda;
    logic oSdaOe;

    modport master (output iScl, output iSda, input  oSdaOe);
    modport slave  (input  iScl, input  iSda, output oSdaOe);
endinterface

// File: rtl/sccb_resp_regfile.sv
// sccb_resp_regfile: 256x8 register file, synchronous write, no reset.
//   I2C_Clock : clock
//   we/waddr/wdata : write port
//   raddr/rdata    : registered read port (1-cycle latency), present only when
//                    SCCB_RESP_READ_EN is defined
module sccb_resp_regfile (
    input  logic       I2C_Clock,
    input  logic       we,
    input  logic [7:0] waddr,
    input  logic [7:0] wdata
`ifdef SCCB_RESP_READ_EN
    ,
    input  logic [7:0] raddr,
    output logic [7:0] rdata
`endif
);
    logic [7:0] mem [0:255];

    always_ff @(posedge I2C_Clock) begin
        if (we) mem[waddr] <= wdata;
`ifdef SCCB_RESP_READ_EN
        rdata <= mem[raddr];
`endif
    end
endmodule

// File: rtl/sccb_cam_responder.sv
// sccb_cam_responder: SCCB/I2C target modelling a camera configuration port.
// Oversamples SCL/SDA, decodes START/STOP, matches DEV_ADDR, takes a register
// pointer byte and writes following data bytes into a 256x8 register file.
// Optional read support is compiled in with `define SCCB_RESP_READ_EN.
// Ports:
//   I2C_Clock : oversampling clock (>= 8x SCL)
//   iReset    : asynchronous active-low reset
//   bus       : SCL/SDA in, SDA pull-down enable out (slave modport)
//   oRegWe    : one-cycle write strobe; oRegAddr/oRegData describe the write
//   oBusy     : high between START and STOP
//   oWrCount  : saturating count of register writes
module sccb_cam_responder
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = SCCB_CAM_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  I2C_Clock,
    input  logic                  iReset,
    sccb_cam_responder_if.slave   bus,
    output logic                  oRegWe,
    output logic [7:0]            oRegAddr,
    output logic [7:0]            oRegData,
    output logic                  oBusy,
    output logic [7:0]            oWrCount
);
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_d, sda_d;
    logic                   sclS, sdaS;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    sccb_resp_state_t state;
    logic [3:0]       bit_cnt;
    logic [7:0]       shift;
    logic [7:0]       ptr;
    logic             sda_oe;
    logic [7:0]       byte_nxt;
    logic             bit_last;

    // Sync flops reset to 1 (idle bus) so reset release never fakes an edge.
    always_ff @(posedge I2C_Clock or negedge iReset) begin
        if (!iReset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.iScl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.iSda};
            scl_d    <= sclS;
            sda_d    <= sdaS;
        end
    end

    assign sclS      = scl_sync[SYNC_STAGES-1];
    assign sdaS      = sda_sync[SYNC_STAGES-1];
    assign scl_rise  =  sclS & ~scl_d;
    assign scl_fall  = ~sclS &  scl_d;
    assign start_det =  sclS &  sda_d & ~sdaS;
    assign stop_det  =  sclS & ~sda_d &  sdaS;
    assign byte_nxt  = {shift[6:0], sdaS};
    assign bit_last  = (bit_cnt == SCCB_BITS - 4'd1);
    assign bus.oSdaOe = sda_oe;

`ifdef SCCB_RESP_READ_EN
    logic       rd_mode;
    logic [7:0] rd_data;
    logic [2:0] rd_idx;
    assign rd_idx = 3'(4'd7 - bit_cnt);
`endif

    // Ack states use sda_oe as their phase bit: first SCL fall asserts the
    // pull-down, the second fall (after the ninth rise) releases it.
    always_ff @(posedge I2C_Clock or negedge iReset) begin
        if (!iReset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            ptr      <= '0;
            sda_oe   <= 1'b0;
            oRegWe   <= 1'b0;
            oRegAddr <= '0;
            oRegData <= '0;
            oBusy    <= 1'b0;
            oWrCount <= '0;
`ifdef SCCB_RESP_READ_EN
            rd_mode  <= 1'b0;
`endif
        end else begin
            oRegWe <= 1'b0;
            if (oRegWe && oWrCount != 8'hFF) oWrCount <= oWrCount + 8'd1;

            if (stop_det) begin
                state   <= IDLE;
                sda_oe  <= 1'b0;
                oBusy   <= 1'b0;
                bit_cnt <= '0;
            end else if (start_det) begin
                state   <= DEVADR;
                sda_oe  <= 1'b0;
                oBusy   <= 1'b1;
                bit_cnt <= '0;
            end else begin
                case (state)
                    DEVADR, REGADR, WRDATA: if (scl_rise) begin
                        shift   <= byte_nxt;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_last) begin
                            bit_cnt <= '0;
                            if (state == DEVADR) begin
                                if (byte_nxt[7:1] == DEV_ADDR && !byte_nxt[0]) begin
`ifdef SCCB_RESP_READ_EN
                                    rd_mode <= 1'b0;
`endif
                                    state <= DEV_ACK;
                                end
`ifdef SCCB_RESP_READ_EN
                                else if (byte_nxt[7:1] == DEV_ADDR) begin
                                    rd_mode <= 1'b1;
                                    state   <= DEV_ACK;
                                end
`endif
                                else state <= IGNORE;
                            end else if (state == REGADR) begin
                                ptr   <= byte_nxt;
                                state <= REG_ACK;
                            end else begin
                                oRegWe   <= 1'b1;
                                oRegAddr <= ptr;
                                oRegData <= byte_nxt;
                                ptr      <= ptr + 8'd1;
                                state    <= WR_ACK;
                            end
                        end
                    end
                    DEV_ACK, REG_ACK, WR_ACK: if (scl_fall) begin
                        if (!sda_oe) sda_oe <= 1'b1;
                        else begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            if (state == DEV_ACK) begin
`ifdef SCCB_RESP_READ_EN
                                if (rd_mode) begin
                                    // First read bit goes out on the same fall that ends the ACK.
                                    sda_oe <= ~rd_data[7];
                                    state  <= RDDATA;
                                end else
`endif
                                state <= REGADR;
                            end else begin
                                state <= WRDATA;
                            end
                        end
                    end
`ifdef SCCB_RESP_READ_EN
                    RDDATA: begin
                        if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
                        else if (scl_fall) begin
                            if (bit_cnt == SCCB_BITS) begin
                                sda_oe <= 1'b0;
                                state  <= RD_ACK;
                            end else begin
                                sda_oe <= ~rd_data[rd_idx];
                            end
                        end
                    end
                    RD_ACK: if (scl_rise) begin
                        if (!sdaS) begin
                            ptr     <= ptr + 8'd1;
                            bit_cnt <= '0;
                            state   <= RDDATA;
                        end else begin
                            state <= IGNORE;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    sccb_resp_regfile u_rf (
        .I2C_Clock (I2C_Clock),
        .we        (oRegWe),
        .waddr     (oRegAddr),
        .wdata     (oRegData)
`ifdef SCCB_RESP_READ_EN
        ,
        .raddr     (ptr),
        .rdata     (rd_data)
`endif
    );
endmodule
